// File: rtl/ogr_result_streamer_pkg.sv
// Shared definitions for the result streamer: sync byte default, frame shape
// constants and FSM state encoding. The CSUM state exists only when the
// OGR_STREAM_CHECKSUM_EN macro is defined.
package ogr_result_streamer_pkg;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // SYNC + COUNT lead every frame
  localparam int unsigned HeaderBytes = 2;

`ifdef OGR_STREAM_CHECKSUM_EN
  localparam int unsigned TrailerBytes = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCount,
    StMark,
    StCsum,
    StHold
  } state_e;
`else
  localparam int unsigned TrailerBytes = 0;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCount,
    StMark,
    StHold
  } state_e;
`endif

endpackage

// File: rtl/ogr_result_streamer_mark_select.sv
// Combinational mark picker: maps (slot, mark) indices to one zero-extended
// byte of the captured results snapshot. Slot 0 and mark 0 live in the MSBs.
module ogr_mark_select #(
  parameter int unsigned NUMPOSITIONS = 5,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned NUM_RESULTS  = 5
) (
  input  logic [(NUMPOSITIONS+1)*POS_W*NUM_RESULTS-1:0] snap_i,
  input  logic [6:0]                                    slot_i,
  input  logic [7:0]                                    mark_i,
  output logic [7:0]                                    mark_byte_o
);

  localparam int unsigned NumMarks = (NUMPOSITIONS + 1) * NUM_RESULTS;

  int unsigned idx;
  int unsigned lsb;

  // Flatten (slot, mark) to a linear index, then count down from the MSB end
  always_comb begin
    mark_byte_o = '0;
    idx         = 32'(slot_i) * (NUMPOSITIONS + 1) + 32'(mark_i);
    lsb         = 0;
    if (idx < NumMarks) begin
      lsb                     = (NumMarks - 1 - idx) * POS_W;
      mark_byte_o[POS_W-1:0]  = snap_i[lsb +: POS_W];
    end
  end

endmodule

// File: rtl/ogr_result_streamer.sv
// Host-facing result streamer: snapshots results when done rises and emits
// SYNC, COUNT, mark bytes (and a trailing XOR checksum when
// OGR_STREAM_CHECKSUM_EN is defined) over a valid/ready byte stream.
module ogr_result_streamer
  import ogr_result_streamer_pkg::*;
#(
  parameter int unsigned NUMPOSITIONS = 5,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned NUM_RESULTS  = 5,
  parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault
) (
  input  logic                                          FXCLK,
  input  logic                                          RESET_IN,
  input  logic                                          done,
  input  logic [(NUMPOSITIONS+1)*POS_W*NUM_RESULTS-1:0] results,
  input  logic [5:0]                                    numResultsObserved,
  output logic [7:0]                                    out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          busy,
  output logic                                          frame_sent
);

  localparam int unsigned ResW = (NUMPOSITIONS + 1) * POS_W * NUM_RESULTS;

  state_e            state_q, state_d;
  logic [ResW-1:0]   snap_q, snap_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [6:0]        slot_q, slot_d;
  logic [7:0]        mark_q, mark_d;
  logic              sent_q, sent_d;
`ifdef OGR_STREAM_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              over;
  logic [6:0]        clamp;
  logic [7:0]        count_byte;
  logic [7:0]        mark_byte;
  logic              accept;
  logic              last_mark;
  logic              last_slot;

  ogr_mark_select #(
    .NUMPOSITIONS (NUMPOSITIONS),
    .POS_W        (POS_W),
    .NUM_RESULTS  (NUM_RESULTS)
  ) u_mark_select (
    .snap_i      (snap_q),
    .slot_i      (slot_q),
    .mark_i      (mark_q),
    .mark_byte_o (mark_byte)
  );

  // Frame header derived from the captured count
  always_comb begin
    over       = 32'(cnt_q) > NUM_RESULTS;
    clamp      = over ? 7'(NUM_RESULTS) : 7'(cnt_q);
    count_byte = {over, clamp};
    last_mark  = (mark_q == 8'(NUMPOSITIONS));
    last_slot  = (slot_q == clamp - 7'd1);
  end

  // Byte presentation is purely a function of registered state, so data
  // and valid stay put while the sink stalls.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = (state_q != StIdle) && (state_q != StHold);
    frame_sent = sent_q;
    unique case (state_q)
      StSync: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
      end
      StCount: begin
        out_valid = 1'b1;
        out_data  = count_byte;
      end
      StMark: begin
        out_valid = 1'b1;
        out_data  = mark_byte;
      end
`ifdef OGR_STREAM_CHECKSUM_EN
      StCsum: begin
        out_valid = 1'b1;
        out_data  = csum_q;
      end
`endif
      default: ;
    endcase
    accept = out_valid && out_ready;
  end

  // Next-state: advance one byte per accepted transfer
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    mark_d  = mark_q;
    sent_d  = 1'b0;
`ifdef OGR_STREAM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (done) begin
          snap_d  = results;
          cnt_d   = numResultsObserved;
          slot_d  = '0;
          mark_d  = '0;
`ifdef OGR_STREAM_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = StSync;
        end
      end
      StSync: begin
        if (accept) state_d = StCount;
      end
      StCount: begin
        if (accept) begin
`ifdef OGR_STREAM_CHECKSUM_EN
          csum_d = csum_q ^ count_byte;
`endif
          if (clamp == 7'd0) begin
`ifdef OGR_STREAM_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StHold;
            sent_d  = 1'b1;
`endif
          end else begin
            state_d = StMark;
          end
        end
      end
      StMark: begin
        if (accept) begin
`ifdef OGR_STREAM_CHECKSUM_EN
          csum_d = csum_q ^ mark_byte;
`endif
          if (last_mark) begin
            mark_d = '0;
            if (last_slot) begin
`ifdef OGR_STREAM_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StHold;
              sent_d  = 1'b1;
`endif
            end else begin
              slot_d = slot_q + 7'd1;
            end
          end else begin
            mark_d = mark_q + 8'd1;
          end
        end
      end
`ifdef OGR_STREAM_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = StHold;
          sent_d  = 1'b1;
        end
      end
`endif
      StHold: begin
        // One frame per done assertion
        if (!done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge FXCLK) begin
    if (RESET_IN) begin
      state_q <= StIdle;
      snap_q  <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      mark_q  <= '0;
      sent_q  <= 1'b0;
`ifdef OGR_STREAM_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      mark_q  <= mark_d;
      sent_q  <= sent_d;
`ifdef OGR_STREAM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
